float_wr_arbiter: RTL
=====================

# float_wr_arbiter

Round-robin write arbiter that shares the single write port of the `float` register block among `NUM_REQ` independent requesters. Each requester presents a `float_pkg::float_t` value under a valid/ready handshake. The arbiter selects one winner per cycle, optionally canonicalises NaN payloads, and drives a registered write strobe and data into `float`'s `wen_i`/`wdata_i`. A high-priority clear request writes +0.0. A write counter and source tag support debug and scoreboarding.

## Interface
- `NUM_REQ`, default 4: number of requesters, 2..16.
- `CANON_NAN`, default 1: when 1, any NaN is written as canonical quiet NaN 32'h7FC0_0000.
- `CNT_W`, default 16: width of the write counter.

Ports:
- `clk_i`  in  1  sole clock; all logic is rising-edge.
- `rst_i`  in  1  reset; synchronous, active-high.
- `req_valid_i`  in  NUM_REQ  per-requester data valid.
- `req_data_i`  in  NUM_REQ x float_t  per-requester value (32 bits: sign[31], exponent[30:23], mantissa[22:0]).
- `req_ready_o`  out  NUM_REQ  one-hot grant/accept; combinational.
- `clear_i`  in  1  request a write of +0.0; outranks all requesters.
- `float_wen_o`  out  1  registered write strobe to `float.wen_i`.
- `float_wdata_o`  out  float_t  registered write data to `float.wdata_i`.
- `grant_id_o`  out  $clog2(NUM_REQ)  index of the requester whose data is on `float_wdata_o`.
- `src_clear_o`  out  1  current write originated from `clear_i`.
- `write_count_o`  out  CNT_W  count of writes issued, wrapping.

## Operation
- **Handshake.** A transfer from requester k occurs in a cycle when `req_valid_i[k] && req_ready_o[k]`.
  - `req_ready_o` has at most one bit set.
  - A bit is set only if the matching `req_valid_i` is high.
- **Arbitration.**
  - Pointer `ptr` has reset value 0.
  - The winner is the first valid index scanning ptr, ptr+1, …, NUM_REQ-1, 0, …, ptr-1.
  - After a transfer, `ptr` becomes winner+1, modulo NUM_REQ, wrapping from NUM_REQ-1 to 0.
  - With no valid requester, `ptr` holds.
- **Clear.**
  - When `clear_i` is high, `req_ready_o` = 0 and `ptr` holds.
  - The next cycle writes 32'h0000_0000 with `src_clear_o`=1 and `grant_id_o`=0.
  - `CANON_NAN` does not apply to a clear write.
- **NaN canonicalisation.**
  - A value is NaN when exponent = 8'hFF and mantissa != 0.
  - With `CANON_NAN`=1, a NaN is written as 32'h7FC0_0000.
  - Infinities, zeros and denormals pass unchanged.
  - With `CANON_NAN`=0, all values pass unchanged.
- **Counter.** `write_count_o` increments by 1 in the cycle `float_wen_o` is registered high, covering both requester and clear writes. It wraps from 2^CNT_W-1 to 0.
- **Requester state.** No data is buffered internally. A requester not granted must hold valid and data; the arbiter does not require this, but an unheld value is simply not written.

## Timing
- **Reset values.** `float_wen_o`=0, `float_wdata_o`=0, `grant_id_o`=0, `src_clear_o`=0, `write_count_o`=0, `ptr`=0. `req_ready_o`=0 while `rst_i` is high.
- **Latency.** A transfer or clear in cycle N produces `float_wen_o`=1, with data/tag, in cycle N+1. `float` captures the value at the N+2 rising edge.
- **Throughput.** One write per cycle. `float_wen_o` drops to 0 in any cycle following one with no transfer and no clear.
- **Held outputs.** `float_wdata_o`, `grant_id_o` and `src_clear_o` hold their last values while `float_wen_o`=0.
- **Reset mid-operation.** `rst_i` overrides everything. A write registered in the cycle `rst_i` is sampled high is discarded, so no strobe follows the reset.
- **Simultaneous clear and valids.** The clear wins. Valids remain pending and compete next cycle from the unchanged `ptr`.
- **Back-to-back clears.** Each cycle of `clear_i` produces one clear write.

## Test plan
All scenarios use NUM_REQ=4.
- **Reset.** Assert `rst_i` 3 cycles with all `req_valid_i`=1 → all outputs are 0 and `req_ready_o`=0 throughout. After release, the first grant goes to index 0.
- **Single requester.** Only req 2 valid, data 32'h3F80_0000 → `req_ready_o`=4'b0100 in the same cycle. Next cycle `float_wen_o`=1, `float_wdata_o`=32'h3F80_0000, `grant_id_o`=2, `write_count_o`=1.
- **Full contention.** All four valid for 8 cycles → grant order is 0,1,2,3,0,1,2,3. `float_wen_o` stays high 8 consecutive cycles. Once valids drop, `float_wen_o` returns to 0.
- **NaN handling.** Write 32'h7F80_0001 and 32'hFFFF_FFFF → both write 32'h7FC0_0000. 32'h7F80_0000 and 32'h8000_0001 pass unchanged. With `CANON_NAN`=0, 32'h7F80_0001 passes unchanged.
- **Clear vs requesters.** `ptr`=1, reqs 1 and 3 valid, `clear_i` pulsed 1 cycle → `req_ready_o`=0 that cycle. Next cycle writes 0 with `src_clear_o`=1. Following cycles grant 1, then 3.
- **Wrap and reset mid-stream.** With `CNT_W`=4 and 17 writes → `write_count_o` reads 1. Asserting `rst_i` in the cycle after a transfer → no strobe follows, and the counter reads 0.

Source files
------------

// File: rtl/float_pkg.sv
// float_pkg: shared IEEE-754 single-precision value type for the float register block
package float_pkg;
    typedef logic [31:0] float_t;
endpackage

// File: rtl/float_wr_arbiter.sv
// float_wr_arbiter: round-robin arbiter sharing the float block write port among NUM_REQ requesters
module float_wr_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int CANON_NAN = 1,
    parameter int CNT_W     = 16
) (
    input  logic                                      clk_i,
    input  logic                                      rst_i,
    input  logic [NUM_REQ-1:0]                        req_valid_i,
    input  float_pkg::float_t [NUM_REQ-1:0]           req_data_i,
    output logic [NUM_REQ-1:0]                        req_ready_o,
    input  logic                                      clear_i,
    output logic                                      float_wen_o,
    output float_pkg::float_t                         float_wdata_o,
    output logic [$clog2(NUM_REQ)-1:0]                grant_id_o,
    output logic                                      src_clear_o,
    output logic [CNT_W-1:0]                          write_count_o
);
    localparam int ID_W = $clog2(NUM_REQ);

    logic [ID_W-1:0]   ptr;
    logic [ID_W-1:0]   win;
    logic [ID_W:0]     idx;
    logic              found;
    logic              grant;
    float_pkg::float_t din;
    float_pkg::float_t wd;

    // first valid requester scanning upward from ptr with wraparound
    always_comb begin
        found = 1'b0;
        win   = '0;
        idx   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = {1'b0, ptr} + (ID_W+1)'(i);
            if (idx >= (ID_W+1)'(NUM_REQ)) idx = idx - (ID_W+1)'(NUM_REQ);
            if (!found && req_valid_i[idx[ID_W-1:0]]) begin
                found = 1'b1;
                win   = idx[ID_W-1:0];
            end
        end
    end

    // grant is suppressed by reset and by a pending clear; NaNs optionally canonicalised
    always_comb begin
        grant       = !rst_i && !clear_i && found;
        req_ready_o = grant ? ({{(NUM_REQ-1){1'b0}}, 1'b1} << win) : '0;
        din         = req_data_i[win];
        wd          = (CANON_NAN != 0 && &din[30:23] && |din[22:0]) ? 32'h7FC0_0000 : din;
    end

    // registered write port, source tag, round-robin pointer and write counter
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            float_wen_o   <= 1'b0;
            float_wdata_o <= '0;
            grant_id_o    <= '0;
            src_clear_o   <= 1'b0;
            write_count_o <= '0;
            ptr           <= '0;
        end else begin
            float_wen_o <= clear_i || grant;
            if (clear_i) begin
                float_wdata_o <= '0;
                grant_id_o    <= '0;
                src_clear_o   <= 1'b1;
            end else if (grant) begin
                float_wdata_o <= wd;
                grant_id_o    <= win;
                src_clear_o   <= 1'b0;
                ptr           <= (win == ID_W'(NUM_REQ-1)) ? '0 : win + 1'b1;
            end
            if (clear_i || grant) write_count_o <= write_count_o + 1'b1;
        end
    end
endmodule
